// File: rtl/hdmi_stream_ctrl_pkg.sv
// Shared encodings for the HDMI stream controller: processing modes, lock states
// and the per-vsync frame event handed from the resolution meter to the top.
package hdmi_stream_ctrl_pkg;

  localparam int unsigned PIX_W  = 24;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned ERR_W  = 8;

  localparam logic [MODE_W-1:0] MODE_BYPASS = 2'd0;
  localparam logic [MODE_W-1:0] MODE_A      = 2'd1;
  localparam logic [MODE_W-1:0] MODE_B      = 2'd2;
  localparam logic [MODE_W-1:0] MODE_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    LK_SEARCH = 2'd0,
    LK_COUNT  = 2'd1,
    LK_LOCKED = 2'd2
  } lock_state_e;

  typedef struct packed {
    logic vs_rise;   // vsync rising edge this cycle
    logic measured;  // vs_rise closing a tracked frame with >=1 line
    logic empty;     // vs_rise closing a tracked frame with no lines
    logic bad;       // closing frame had inconsistent line widths
    logic same;      // closing frame matches previously measured w/h
  } frame_evt_t;

  function automatic logic [MODE_W-1:0] commit_mode(input logic [MODE_W-1:0] req);
    return (req == MODE_RSVD) ? MODE_BYPASS : req;
  endfunction

  function automatic logic is_proc(input logic [MODE_W-1:0] mode);
    return (mode == MODE_A) || (mode == MODE_B);
  endfunction

endpackage

// File: rtl/hdmi_res_meter.sv
// Resolution meter: de/vsync edge detection, pixel coordinates, line/frame strobes,
// line-width consistency check and measured width/height of the last frame.
module hdmi_res_meter
  import hdmi_stream_ctrl_pkg::*;
#(
  parameter int unsigned X_W = 11,
  parameter int unsigned Y_W = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_de,
  input  logic           in_vsync,
  input  logic           clear,
  output logic [X_W-1:0] x_pos,
  output logic [Y_W-1:0] y_pos,
  output logic           frame_start,
  output logic           line_start,
  output logic [X_W-1:0] meas_w,
  output logic [Y_W-1:0] meas_h,
  output frame_evt_t     evt_c
);

  logic           de_q;
  logic           vs_q;
  logic           synced;
  logic           frame_bad;
  logic [X_W-1:0] ref_w;

  logic           vs_rise_c;
  logic           de_rise_c;
  logic           de_fall_c;
  logic [X_W-1:0] line_w_c;

  assign vs_rise_c = in_vsync & ~vs_q;
  assign de_rise_c = in_de & ~de_q;
  assign de_fall_c = ~in_de & de_q;
  assign line_w_c  = x_pos + X_W'(1);

  // Frame summary presented to the lock logic on the vsync edge itself
  always_comb begin
    evt_c          = '0;
    evt_c.vs_rise  = vs_rise_c;
    evt_c.measured = vs_rise_c && synced && (y_pos != '0);
    evt_c.empty    = vs_rise_c && synced && (y_pos == '0);
    evt_c.bad      = frame_bad;
    evt_c.same     = (ref_w == meas_w) && (y_pos == meas_h);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q        <= 1'b0;
      vs_q        <= 1'b0;
      synced      <= 1'b0;
      frame_bad   <= 1'b0;
      ref_w       <= '0;
      x_pos       <= '0;
      y_pos       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      meas_w      <= '0;
      meas_h      <= '0;
    end else begin
      de_q        <= in_de;
      vs_q        <= in_vsync;
      line_start  <= de_rise_c;
      frame_start <= de_rise_c && (vs_rise_c || (y_pos == '0));

      if (clear && !vs_rise_c) begin
        x_pos <= '0;
      end else if (in_de) begin
        x_pos <= de_rise_c ? '0 : x_pos + X_W'(1);
      end

      // vsync edge wins over a coincident line end; measurement only once tracking began
      if (vs_rise_c) begin
        y_pos     <= '0;
        frame_bad <= 1'b0;
        synced    <= 1'b1;
        if (evt_c.measured) begin
          meas_w <= ref_w;
          meas_h <= y_pos;
        end
      end else if (clear) begin
        y_pos     <= '0;
        frame_bad <= 1'b0;
        synced    <= 1'b0;
      end else if (de_fall_c) begin
        y_pos <= y_pos + Y_W'(1);
        if (y_pos == '0) begin
          ref_w <= line_w_c;
        end else if (line_w_c != ref_w) begin
          frame_bad <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hdmi_stream_ctrl.sv
// HDMI stream sequencing controller: 1-cycle pass-through, resolution lock,
// vsync timeout and frame-boundary commit of the processing mode.
module hdmi_stream_ctrl
  import hdmi_stream_ctrl_pkg::*;
#(
  parameter int unsigned X_W      = 11,
  parameter int unsigned Y_W      = 11,
  parameter int unsigned LOCK_FRM = 2,
  parameter int unsigned TO_W     = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_de,
  input  logic             in_hsync,
  input  logic             in_vsync,
  input  logic [23:0]      in_pixel,
  input  logic [1:0]       mode_req,
  output logic             out_de,
  output logic             out_hsync,
  output logic             out_vsync,
  output logic [23:0]      out_pixel,
  output logic [X_W-1:0]   x_pos,
  output logic [Y_W-1:0]   y_pos,
  output logic             frame_start,
  output logic             line_start,
  output logic [X_W-1:0]   meas_w,
  output logic [Y_W-1:0]   meas_h,
  output logic             locked,
  output logic             no_signal,
  output logic [1:0]       active_mode,
  output logic             proc_en,
  output logic [7:0]       err_cnt
);

  localparam int unsigned CNT_W = $clog2(LOCK_FRM + 1);

  frame_evt_t        evt_c;
  logic              timeout_c;
  logic [MODE_W-1:0] mode_q;
  logic [TO_W-1:0]   to_cnt;
  lock_state_e       lock_state;
  lock_state_e       lock_state_d;
  logic [CNT_W-1:0]  lock_cnt;
  logic [CNT_W-1:0]  lock_cnt_d;
  logic [MODE_W-1:0] mode_d;

  // A vsync edge in the same cycle as expiry counts as signal present
  assign timeout_c = (to_cnt == '1) && !evt_c.vs_rise;

  hdmi_res_meter #(
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_meter (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_de       (in_de),
    .in_vsync    (in_vsync),
    .clear       (timeout_c),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .frame_start (frame_start),
    .line_start  (line_start),
    .meas_w      (meas_w),
    .meas_h      (meas_h),
    .evt_c       (evt_c)
  );

  // Lock state and mode commit, evaluated only on vsync edges or timeout
  always_comb begin
    lock_state_d = lock_state;
    lock_cnt_d   = lock_cnt;
    mode_d       = active_mode;
    if (timeout_c) begin
      lock_state_d = LK_SEARCH;
      lock_cnt_d   = '0;
      mode_d       = MODE_BYPASS;
    end else if (evt_c.vs_rise) begin
      mode_d = commit_mode(mode_q);
      if (evt_c.empty) begin
        lock_state_d = LK_SEARCH;
        lock_cnt_d   = '0;
      end else if (evt_c.measured) begin
        if (evt_c.bad) begin
          if (lock_state != LK_SEARCH) begin
            lock_state_d = LK_COUNT;
            lock_cnt_d   = CNT_W'(1);
          end
        end else if ((lock_state == LK_SEARCH) || !evt_c.same) begin
          lock_cnt_d   = CNT_W'(1);
          lock_state_d = (LOCK_FRM <= 1) ? LK_LOCKED : LK_COUNT;
        end else if (lock_state == LK_COUNT) begin
          lock_cnt_d = lock_cnt + CNT_W'(1);
          if (lock_cnt_d >= CNT_W'(LOCK_FRM)) begin
            lock_state_d = LK_LOCKED;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_de      <= 1'b0;
      out_hsync   <= 1'b0;
      out_vsync   <= 1'b0;
      out_pixel   <= '0;
      mode_q      <= MODE_BYPASS;
      active_mode <= MODE_BYPASS;
      lock_state  <= LK_SEARCH;
      lock_cnt    <= '0;
      locked      <= 1'b0;
      proc_en     <= 1'b0;
      err_cnt     <= '0;
      to_cnt      <= '0;
      no_signal   <= 1'b1;
    end else begin
      out_de      <= in_de;
      out_hsync   <= in_hsync;
      out_vsync   <= in_vsync;
      out_pixel   <= in_pixel;
      mode_q      <= mode_req;
      active_mode <= mode_d;
      lock_state  <= lock_state_d;
      lock_cnt    <= lock_cnt_d;
      locked      <= (lock_state_d == LK_LOCKED);
      proc_en     <= (lock_state_d == LK_LOCKED) && is_proc(mode_d);

      if (evt_c.vs_rise) begin
        to_cnt    <= '0;
        no_signal <= 1'b0;
      end else if (to_cnt == '1) begin
        no_signal <= 1'b1;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      if (evt_c.measured && evt_c.bad && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_hdmi_stream_ctrl.sv
// Directed bench for hdmi_stream_ctrl: 64x48 frames, lock/relock, mode commit,
// vsync timeout and mid-frame reset, all against hand-computed expectations.
module tb_hdmi_stream_ctrl;

  localparam int X_W   = 11;
  localparam int Y_W   = 11;
  localparam int TO_W  = 13;  // timeout must exceed one frame period (52 lines x 80 clocks)
  localparam int H_ACT = 64;
  localparam int H_TOT = 80;
  localparam int V_ACT = 48;
  localparam int V_BLK = 4;

  logic           clk;
  logic           rst_n;
  logic           in_de;
  logic           in_hsync;
  logic           in_vsync;
  logic [23:0]    in_pixel;
  logic [1:0]     mode_req;
  logic           out_de;
  logic           out_hsync;
  logic           out_vsync;
  logic [23:0]    out_pixel;
  logic [X_W-1:0] x_pos;
  logic [Y_W-1:0] y_pos;
  logic           frame_start;
  logic           line_start;
  logic [X_W-1:0] meas_w;
  logic [Y_W-1:0] meas_h;
  logic           locked;
  logic           no_signal;
  logic [1:0]     active_mode;
  logic           proc_en;
  logic [7:0]     err_cnt;

  int n_checks;
  int n_fail;
  int fs_cnt;
  int ls_cnt;

  hdmi_stream_ctrl #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .LOCK_FRM (2),
    .TO_W     (TO_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_de       (in_de),
    .in_hsync    (in_hsync),
    .in_vsync    (in_vsync),
    .in_pixel    (in_pixel),
    .mode_req    (mode_req),
    .out_de      (out_de),
    .out_hsync   (out_hsync),
    .out_vsync   (out_vsync),
    .out_pixel   (out_pixel),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .frame_start (frame_start),
    .line_start  (line_start),
    .meas_w      (meas_w),
    .meas_h      (meas_h),
    .locked      (locked),
    .no_signal   (no_signal),
    .active_mode (active_mode),
    .proc_en     (proc_en),
    .err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one pixel clock; outputs are sampled 1 time unit after the edge
  task automatic tick(input logic de, input logic hs, input logic vs, input logic [23:0] pix);
    in_de    = de;
    in_hsync = hs;
    in_vsync = vs;
    in_pixel = pix;
    @(posedge clk);
    #1;
    if (frame_start) fs_cnt++;
    if (line_start) ls_cnt++;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_out_de"},  32'(out_de),      32'd0);
    chk({tag, "_out_vs"},  32'(out_vsync),   32'd0);
    chk({tag, "_out_pix"}, 32'(out_pixel),   32'd0);
    chk({tag, "_x"},       32'(x_pos),       32'd0);
    chk({tag, "_y"},       32'(y_pos),       32'd0);
    chk({tag, "_mw"},      32'(meas_w),      32'd0);
    chk({tag, "_mh"},      32'(meas_h),      32'd0);
    chk({tag, "_locked"},  32'(locked),      32'd0);
    chk({tag, "_nosig"},   32'(no_signal),   32'd1);
    chk({tag, "_mode"},    32'(active_mode), 32'd0);
    chk({tag, "_proc"},    32'(proc_en),     32'd0);
    chk({tag, "_err"},     32'(err_cnt),     32'd0);
  endtask

  // First cycle of a frame: vsync rises; lk < 0 skips the lock/proc checks
  task automatic vs_pulse(input string tag, input int mw, input int mh, input int lk,
                          input int am, input int pe, input int ec);
    tick(1'b0, 1'b0, 1'b1, 24'h0);
    chk({tag, "_out_vs"}, 32'(out_vsync),   32'd1);
    chk({tag, "_nosig"},  32'(no_signal),   32'd0);
    chk({tag, "_mw"},     32'(meas_w),      32'(mw));
    chk({tag, "_mh"},     32'(meas_h),      32'(mh));
    chk({tag, "_mode"},   32'(active_mode), 32'(am));
    chk({tag, "_err"},    32'(err_cnt),     32'(ec));
    if (lk >= 0) begin
      chk({tag, "_locked"}, 32'(locked),  32'(lk));
      chk({tag, "_proc"},   32'(proc_en), 32'(pe));
    end
  endtask

  // Rest of the frame after the vsync edge cycle
  task automatic frame_body(input int short_line, input int rst_line,
                            input int m_line, input logic [1:0] m_val,
                            input int m2_line, input logic [1:0] m2_val);
    fs_cnt = 0;
    ls_cnt = 0;
    for (int c = 1; c < H_TOT; c++) tick(1'b0, 1'b0, 1'b1, 24'h0);
    for (int l = 1; l < V_BLK; l++)
      for (int c = 0; c < H_TOT; c++) tick(1'b0, (c >= H_ACT + 4) && (c < H_ACT + 10), 1'b0, 24'h0);
    for (int a = 0; a < V_ACT; a++) begin
      if (a == m_line) mode_req = m_val;
      if (a == m2_line) mode_req = m2_val;
      for (int c = 0; c < H_TOT; c++) begin
        logic        de;
        logic [23:0] pix;
        de  = (c < ((a == short_line) ? H_ACT - 1 : H_ACT));
        pix = (c == 10 && a == 5) ? 24'h123456 : {8'(c), 8'(a), 8'hA5};
        if (a == rst_line && c == 30) begin
          rst_n = 1'b0;
          #1;
          check_reset("mid_rst");
        end
        tick(de, (c >= H_ACT + 4) && (c < H_ACT + 10), 1'b0, de ? pix : 24'h0);
        if (!rst_n) rst_n = 1'b1;
        if (de && c == 10 && a == 5) begin
          chk("pix_val", 32'(out_pixel), 32'h123456);
          chk("pix_x",   32'(x_pos),     32'd10);
          chk("pix_y",   32'(y_pos),     32'd5);
          chk("pix_de",  32'(out_de),    32'd1);
        end
      end
    end
    if (rst_line < 0) begin
      chk("frame_start_cnt", 32'(fs_cnt), 32'd1);
      chk("line_start_cnt",  32'(ls_cnt), 32'(V_ACT));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    fs_cnt   = 0;
    ls_cnt   = 0;
    rst_n    = 1'b0;
    in_de    = 1'b0;
    in_hsync = 1'b0;
    in_vsync = 1'b0;
    in_pixel = 24'h0;
    mode_req = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;
    repeat (5) tick(1'b0, 1'b0, 1'b0, 24'h0);
    chk("por_nosig_hold", 32'(no_signal), 32'd1);

    // Three clean frames; mode request raised mid frame 2
    vs_pulse("vs1", 0, 0, 0, 0, 0, 0);
    frame_body(-1, -1, -1, 2'd0, -1, 2'd0);
    vs_pulse("vs2", 64, 48, 0, 0, 0, 0);
    frame_body(-1, -1, 20, 2'd1, -1, 2'd0);
    chk("mode_hold", 32'(active_mode), 32'd0);
    chk("proc_hold", 32'(proc_en), 32'd0);
    vs_pulse("vs3", 64, 48, 1, 1, 1, 0);
    frame_body(-1, -1, -1, 2'd0, -1, 2'd0);
    vs_pulse("vs4", 64, 48, 1, 1, 1, 0);

    // Frame with a 63-pixel line, then clean frames to relock
    frame_body(20, -1, -1, 2'd0, -1, 2'd0);
    vs_pulse("vs5_bad", 64, 48, 0, 1, 0, 1);
    frame_body(-1, -1, -1, 2'd0, -1, 2'd0);
    vs_pulse("vs6", 64, 48, -1, 1, 0, 1);
    frame_body(-1, -1, -1, 2'd0, -1, 2'd0);
    vs_pulse("vs7_relock", 64, 48, 1, 1, 1, 1);

    // Signal loss: no vsync for 2**TO_W cycles
    for (int i = 1; i <= (1 << TO_W) + 8; i++) begin
      tick(1'b0, 1'b0, 1'b0, 24'h0);
      if (i == (1 << TO_W) - 1) chk("to_before", 32'(no_signal), 32'd0);
      if (i == (1 << TO_W)) chk("to_at", 32'(no_signal), 32'd1);
    end
    chk("to_locked", 32'(locked),      32'd0);
    chk("to_mode",   32'(active_mode), 32'd0);
    chk("to_proc",   32'(proc_en),     32'd0);
    chk("to_x",      32'(x_pos),       32'd0);
    chk("to_y",      32'(y_pos),       32'd0);
    chk("to_mw",     32'(meas_w),      32'd64);

    // Resume; request toggles away and back within one frame, then reserved code
    vs_pulse("vs8_resume", 64, 48, 0, 1, 0, 1);
    frame_body(-1, -1, 10, 2'd2, 30, 2'd1);
    vs_pulse("vs9", 64, 48, 0, 1, 0, 1);
    frame_body(-1, -1, 10, 2'd3, -1, 2'd0);
    vs_pulse("vs10_rsvd", 64, 48, 1, 0, 0, 1);

    // Reset at pixel (30,30), then relock from scratch
    frame_body(-1, 30, -1, 2'd0, -1, 2'd0);
    vs_pulse("vs11", 0, 0, 0, 0, 0, 0);
    frame_body(-1, -1, 10, 2'd2, -1, 2'd0);
    vs_pulse("vs12", 64, 48, 0, 2, 0, 0);
    frame_body(-1, -1, -1, 2'd0, -1, 2'd0);
    vs_pulse("vs13", 64, 48, 1, 2, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
